// File: rtl/pipelined_cache_pkg.sv
// Shared types and constants for the pipelined L1 cache memory-side logic.
package pipelined_cache_pkg;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_port_state_e;

    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/pipelined_cache_wb_buffer.sv
// One-entry write-back buffer: holds one evicted line and its tag so the port
// can answer the requester at once and drain the line to memory later.
module pipelined_cache_wb_buffer
    import pipelined_cache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int TAG_W  = 32 - OFFSET_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] line_i,
    output logic              valid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    output logic              hit_o
);

    logic              valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [LINE_W-1:0] line_q, line_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        tag_d   = tag_q;
        line_d  = line_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
            line_d  = line_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: payload storage is not reset; it is only ever read while valid_q is set.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign line_o  = line_q;
    assign hit_o   = valid_q && (tag_q == tag_i);

endmodule

// File: rtl/pipelined_cache_mem_port.sv
// Converts cache line fills/write-backs into BEAT_W-wide memory bursts.
// Define WB_BUFFER_EN to add a one-entry write-back buffer in front of memory.
module pipelined_cache_mem_port
    import pipelined_cache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read_i,
    input  logic              line_write_i,
    input  logic [31:0]       line_addr_i,
    input  logic [LINE_W-1:0] line_wdata_i,
    output logic [LINE_W-1:0] line_rdata_o,
    output logic              line_resp_o,
    output logic [31:0]       burst_addr_o,
    output logic              burst_read_o,
    output logic              burst_write_o,
    output logic [BEAT_W-1:0] burst_wdata_o,
    input  logic [BEAT_W-1:0] burst_rdata_i,
    input  logic              burst_resp_i
);

    localparam int               NBEATS    = LINE_W / BEAT_W;
    localparam int               CNT_W     = $clog2(NBEATS);
    localparam int               TAG_W     = 32 - OFFSET_BITS;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    mem_port_state_e            state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       drain_q, drain_d;
    logic [LINE_W-1:0]          rdata_q, rdata_d;
    logic [LINE_W-BEAT_W-1:0]   stage_q, stage_d;

    logic                       buf_valid, buf_hit, buf_capture, buf_clear;
    logic [TAG_W-1:0]           buf_tag;
    logic [LINE_W-1:0]          buf_line;

    logic [TAG_W-1:0]           req_tag;
    logic [TAG_W-1:0]           src_tag;
    logic [LINE_W-1:0]          src_line;
    logic                       unused_offset;

    assign req_tag       = line_addr_i[31:OFFSET_BITS];
    assign unused_offset = ^line_addr_i[OFFSET_BITS-1:0];

`ifdef WB_BUFFER_EN
    localparam bit WB_EN = 1'b1;

    pipelined_cache_wb_buffer #(
        .LINE_W (LINE_W),
        .TAG_W  (TAG_W)
    ) u_wb_buffer (
        .clk       (clk),
        .rst       (rst),
        .capture_i (buf_capture),
        .clear_i   (buf_clear),
        .tag_i     (req_tag),
        .line_i    (line_wdata_i),
        .valid_o   (buf_valid),
        .tag_o     (buf_tag),
        .line_o    (buf_line),
        .hit_o     (buf_hit)
    );
`else
    localparam bit WB_EN = 1'b0;
    logic unused_buf_ctrl;

    assign buf_valid       = 1'b0;
    assign buf_hit         = 1'b0;
    assign buf_tag         = '0;
    assign buf_line        = '0;
    assign unused_buf_ctrl = buf_capture ^ buf_clear;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        rdata_d     = rdata_q;
        stage_d     = stage_q;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                drain_d = 1'b0;
                // Reads go first; an idle cycle or a blocked write drains the buffer.
                if (line_read_i) begin
                    if (buf_hit) begin
                        rdata_d = buf_line;
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end else if (line_write_i && WB_EN && !buf_valid) begin
                    buf_capture = 1'b1;
                    state_d     = DONE;
                end else if (buf_valid) begin
                    drain_d = 1'b1;
                    state_d = WRITE;
                end else if (line_write_i) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (burst_resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    for (int i = 0; i < NBEATS - 1; i++) begin
                        if (cnt_q == CNT_W'(i)) stage_d[i*BEAT_W +: BEAT_W] = burst_rdata_i;
                    end
                    // The visible fill data only changes once the whole line is in.
                    if (cnt_q == LAST_BEAT) begin
                        rdata_d = {burst_rdata_i, stage_q};
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (burst_resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                buf_clear = drain_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    // A drain sources address and data from the buffer, otherwise from the held request.
    assign src_tag  = drain_q ? buf_tag  : req_tag;
    assign src_line = drain_q ? buf_line : line_wdata_i;

    always_comb begin
        burst_wdata_o = '0;
        if (state_q == WRITE) begin
            for (int i = 0; i < NBEATS; i++) begin
                if (cnt_q == CNT_W'(i)) burst_wdata_o = src_line[i*BEAT_W +: BEAT_W];
            end
        end
    end

    assign burst_read_o  = (state_q == READ);
    assign burst_write_o = (state_q == WRITE);
    assign burst_addr_o  = (burst_read_o || burst_write_o) ? {src_tag, {OFFSET_BITS{1'b0}}} : '0;
    assign line_resp_o   = (state_q == DONE) && !drain_q;
    assign line_rdata_o  = rdata_q;

endmodule
